// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage vs. debug/loader, fixed CPU
// priority with a starvation guard. Define DMEM_ARB_PERF_EN to build stall_count.
module dmem_port_arbiter #(
  parameter int AW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic          fwd_sel,
  input  logic [15:0]   fwd_data,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [15:0]   cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [15:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [15:0]   dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   stall_count
);

  typedef enum logic [1:0] {D_IDLE, D_ISSUED, D_ACK} dstate_t;

  dstate_t       r_state;
  logic [3:0]    r_starve_cnt;
  logic          r_mem_en, r_mem_we, r_cpu_rd, r_cpu_rvalid, r_dbg_ack;
  logic [AW-1:0] r_mem_addr;
  logic [15:0]   r_mem_wdata;

  logic w_dbg_elig, w_grant_dbg, w_grant_cpu, w_starved;

  assign w_dbg_elig  = dbg_req && (r_state == D_IDLE);
  assign w_starved   = (r_starve_cnt == 4'(STARVE_MAX));
  assign w_grant_dbg = w_dbg_elig && (!cpu_req || w_starved);
  assign w_grant_cpu = cpu_req && !w_grant_dbg;
  assign cpu_stall   = cpu_req && w_grant_dbg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_dbg) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= dbg_we;
      r_mem_addr  <= dbg_addr;
      r_mem_wdata <= dbg_wdata;
    end else if (w_grant_cpu) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= cpu_we;
      r_mem_addr  <= cpu_addr;
      r_mem_wdata <= fwd_sel ? fwd_data : cpu_wdata;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_starve_cnt <= '0;
    else if (w_grant_dbg || !w_dbg_elig)
      r_starve_cnt <= '0;
    else if (w_grant_cpu && !w_starved)
      r_starve_cnt <= r_starve_cnt + 4'd1;
  end

  // dbg_ack is a registered decode of the ACK state; read data arrives with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= D_IDLE;
      r_dbg_ack <= 1'b0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        D_IDLE:   if (w_grant_dbg) r_state <= D_ISSUED;
        D_ISSUED: begin
          r_state   <= D_ACK;
          r_dbg_ack <= 1'b1;
        end
        default:  r_state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rd     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_cpu_rd     <= w_grant_cpu && !cpu_we;
      r_cpu_rvalid <= r_cpu_rd;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] r_stall_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= '0;
    else if (cpu_stall && r_stall_count != 16'hFFFF)
      r_stall_count <= r_stall_count + 16'd1;
  end
  assign stall_count = r_stall_count;
`else
  assign stall_count = 16'h0000;
`endif

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = mem_rdata;
  assign dbg_ack    = r_dbg_ack;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous memory model.
module tb_dmem_port_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cpu_req = 0, cpu_we = 0, fwd_sel = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_wdata = '0, fwd_data = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [15:0]   cpu_rdata;
  logic          dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] dbg_addr = '0;
  logic [15:0]   dbg_wdata = '0;
  logic          dbg_ack;
  logic [15:0]   dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata, stall_count;

  int n_chk = 0, n_err = 0;

  dmem_port_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[8'h20] = 16'hBEEF;
    mem[8'h30] = 16'hC0DE;
    mem[8'h05] = 16'h0000;
    mem_rdata  = 16'h0000;

    // reset state
    #12;
    chk("rst_mem_en",  32'(mem_en), 0);
    chk("rst_mem_we",  32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_dbg_ack", 32'(dbg_ack), 0);
    chk("rst_rvalid",  32'(cpu_rvalid), 0);
    chk("rst_stallcnt", 32'(stall_count), 0);
    rst_n = 1'b1;
    step();

    // 1: plain store
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h12; cpu_wdata = 16'hAAAA; fwd_sel = 0;
    #1 chk("t1_stall", 32'(cpu_stall), 0);
    step();
    cpu_req = 0;
    chk("t1_en",    32'(mem_en), 1);
    chk("t1_we",    32'(mem_we), 1);
    chk("t1_addr",  32'(mem_addr), 32'h12);
    chk("t1_wdata", 32'(mem_wdata), 32'hAAAA);

    // 2: forwarded store data
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h13; cpu_wdata = 16'h1111;
    fwd_sel = 1; fwd_data = 16'h5A5A;
    step();
    cpu_req = 0; fwd_sel = 0;
    chk("t2_wdata", 32'(mem_wdata), 32'h5A5A);
    step();
    chk("t2_idle_en", 32'(mem_en), 0);
    chk("t2_hold_addr", 32'(mem_addr), 32'h13);

    // 3: load with 2-cycle latency
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    step();
    cpu_req = 0;
    chk("t3_rvalid_n1", 32'(cpu_rvalid), 0);
    step();
    chk("t3_rvalid_n2", 32'(cpu_rvalid), 1);
    chk("t3_rdata",     32'(cpu_rdata), 32'hBEEF);
    step();
    chk("t3_rvalid_n3", 32'(cpu_rvalid), 0);

    // 4: starvation guard under continuous CPU loads
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h30;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t4_stall_c%0d", k), 32'(cpu_stall), 0);
      step();
      chk($sformatf("t4_cpu_addr_c%0d", k), 32'(mem_addr), 32'h05);
    end
    #1 chk("t4_stall_c4", 32'(cpu_stall), 1);
    step();
    chk("t4_iss_addr", 32'(mem_addr), 32'h30);
    chk("t4_iss_we",   32'(mem_we), 0);
    chk("t4_iss_ack",  32'(dbg_ack), 0);
    chk("t4_iss_stall", 32'(cpu_stall), 0);
    step();
    chk("t4_ack",   32'(dbg_ack), 1);
    chk("t4_rdata", 32'(dbg_rdata), 32'hC0DE);
    chk("t4_starve", 32'(dut.r_starve_cnt), 0);
    step();
    dbg_req = 0; cpu_req = 0;
    chk("t4_ack_drop", 32'(dbg_ack), 0);
`ifdef DMEM_ARB_PERF_EN
    chk("t4_stallcnt", 32'(stall_count), 1);
`else
    chk("t4_stallcnt", 32'(stall_count), 0);
`endif
    step();

    // 5: debug write with idle CPU, then CPU readback
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 16'h1234;
    #1 chk("t5_stall", 32'(cpu_stall), 0);
    step();
    chk("t5_en",    32'(mem_en), 1);
    chk("t5_we",    32'(mem_we), 1);
    chk("t5_addr",  32'(mem_addr), 32'h40);
    chk("t5_wdata", 32'(mem_wdata), 32'h1234);
    chk("t5_ack_n1", 32'(dbg_ack), 0);
    step();
    chk("t5_ack_n2", 32'(dbg_ack), 1);
    step();
    dbg_req = 0;
    chk("t5_ack_n3", 32'(dbg_ack), 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
    step();
    cpu_req = 0;
    step();
    chk("t5_rb_rvalid", 32'(cpu_rvalid), 1);
    chk("t5_rb_rdata",  32'(cpu_rdata), 32'h1234);
    step();

    // 6: reset while debug access is in flight
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h50; dbg_wdata = 16'h7777;
    step();
    chk("t6_issued_en", 32'(mem_en), 1);
    rst_n = 0;
    #1;
    chk("t6_rst_en",    32'(mem_en), 0);
    chk("t6_rst_we",    32'(mem_we), 0);
    chk("t6_rst_addr",  32'(mem_addr), 0);
    chk("t6_rst_wdata", 32'(mem_wdata), 0);
    dbg_req = 0;
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_no_ack_%0d", k), 32'(dbg_ack), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences all accesses to the 16-bit data memory and shares its single port between the CPU MEM stage and the debug/loader port.
- Absorbs the write-data select (forwarded WB value vs. register-file store value) and registers it together with the address and write strobe.
- Fixed CPU priority, with a starvation guard so that debug traffic always makes progress.

Parameters:
- AW, 8, data memory address width.
- STARVE_MAX, 4, number of consecutive cycles debug may wait while the CPU is granted before debug is forced through (1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage needs a memory access this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  16  store data from the register file.
- fwd_sel  in  1  1 = use fwd_data as store data.
- fwd_data  in  16  forwarded WB-stage value.
- cpu_stall  out  1  combinational; CPU must hold its request.
- cpu_rvalid  out  1  load data valid on cpu_rdata.
- cpu_rdata  out  16  load data.
- dbg_req  in  1  debug access request, held until dbg_ack.
- dbg_we  in  1  debug write.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  16  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  16  debug read data, valid with dbg_ack.
- mem_en  out  1  registered memory enable.
- mem_we  out  1  registered write enable.
- mem_addr  out  AW  registered address.
- mem_wdata  out  16  registered write data.
- mem_rdata  in  16  synchronous memory read data, valid 1 cycle after mem_en.
- stall_count  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, dbg_ack=0, cpu_rvalid=0, starve_cnt=0, debug FSM in D_IDLE, stall_count=0.
  - Reset mid-access aborts any outstanding debug access; no dbg_ack is issued afterwards.
- Debug eligibility: dbg_elig = dbg_req && fsm==D_IDLE.
- Grant decision for cycle N, evaluated combinationally:
  - If dbg_elig && (!cpu_req || starve_cnt==STARVE_MAX): grant DBG.
  - Else if cpu_req: grant CPU.
  - Else: grant none.
- cpu_stall = cpu_req && grant==DBG. The CPU is never stalled otherwise.
- Registered memory command at the edge ending cycle N:
  - Grant CPU: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata = fwd_sel ? fwd_data : cpu_wdata.
  - Grant DBG: mem_en=1, mem_we=dbg_we, mem_addr=dbg_addr, mem_wdata=dbg_wdata.
  - Grant none: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their previous values.
- starve_cnt update:
  - Cleared when DBG is granted or dbg_elig=0.
  - Incremented, saturating at STARVE_MAX, when dbg_elig && grant==CPU.
- Debug FSM:
  - D_IDLE -> D_ISSUED on DBG grant. The command is on mem_* during D_ISSUED.
  - D_ISSUED -> D_ACK unconditionally.
  - In D_ACK: dbg_ack=1 and dbg_rdata=mem_rdata (read data is don't-care for writes).
  - D_ACK -> D_IDLE unconditionally. Debug requests are ignored in D_ISSUED and D_ACK, so there is no double issue.
  - The requester drops dbg_req in the cycle after dbg_ack.
- CPU loads:
  - A one-bit pipeline flag is set when a CPU read is placed on mem_*.
  - cpu_rvalid=1 in the following cycle, with cpu_rdata=mem_rdata.
  - Latency from grant cycle N to data is N+2.
  - CPU stores produce no response.
- Timing:
  - Back-to-back CPU accesses issue every cycle.
  - Debug throughput is at most 1 access per 3 cycles.
  - Worst-case debug wait under continuous CPU traffic is STARVE_MAX+1 cycles.
- Simultaneous cpu_req and dbg_req with starve_cnt < STARVE_MAX: CPU wins and starve_cnt increments.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined: stall_count increments by 1 on every cycle with cpu_stall=1, saturates at 16'hFFFF, and resets to 0.
- When undefined: no counter logic is built and stall_count is driven constant 0.

Test Plan:
1. CPU store 0x12, cpu_wdata=0xAAAA, fwd_sel=0 -> next cycle mem_en=1, mem_we=1, mem_addr=0x12, mem_wdata=0xAAAA; cpu_stall stays 0.
2. CPU store with fwd_sel=1, fwd_data=0x5A5A, cpu_wdata=0x1111 -> mem_wdata=0x5A5A.
3. CPU load 0x20 with memory holding 0xBEEF -> cpu_rvalid=1 and cpu_rdata=0xBEEF exactly 2 cycles after the request cycle.
4. Continuous cpu_req plus debug read 0x30, STARVE_MAX=4:
   - CPU is granted for 4 cycles, then on cycle 5 cpu_stall=1 and debug is issued.
   - dbg_ack=1 two cycles later with dbg_rdata equal to mem[0x30].
   - starve_cnt returns to 0.
5. Debug write 0x40=0x1234 with cpu_req=0 -> issued in the next cycle; dbg_ack on the third cycle; a subsequent CPU load of 0x40 returns 0x1234.
6. rst_n low while FSM is in D_ISSUED -> all mem_* are 0 immediately and dbg_ack never pulses. With DMEM_ARB_PERF_EN defined, the scenario 4 run ends with stall_count=1.
